xpb_accum: RTL

- Downstream consumer of the per-chunk xpb lookup tables in the modular-square reduction path.
- Receives one precomputed 1024-bit xpb term per handshake and adds it to a base value (the low-order product portion) in carry-save form.
- After all terms are accepted, resolves the redundant sum with a segmented carry-propagate adder.
- Presents the resulting partially reduced value to the next stage over a valid/ready handshake.

---
 rtl/xpb_accum_pkg.sv | 34 +++
 rtl/xpb_accum_csa_3to2.sv | 19 +
 rtl/xpb_accum.sv | 129 ++++++++++++
 3 files changed

// File: rtl/xpb_accum_pkg.sv
// Shared sizing and state encoding for the xpb accumulator (carry-save sum of
// xpb terms followed by a segmented carry-propagate resolve).
package xpb_accum_pkg;

    localparam int WIDTH     = 1024;
    localparam int NUM_TERMS = 32;
    localparam int SEG       = 64;

    function automatic int calc_guard(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

    function automatic int calc_rw(input int width, input int n_terms);
        return width + calc_guard(n_terms);
    endfunction

    function automatic int calc_nseg(input int rw, input int seg);
        return (rw + seg - 1) / seg;
    endfunction

    localparam int GUARD     = calc_guard(NUM_TERMS);
    localparam int RW        = calc_rw(WIDTH, NUM_TERMS);
    localparam int NSEG      = calc_nseg(RW, SEG);
    localparam int SEG_IDX_W = $clog2(NSEG);
    localparam int COUNT_W   = GUARD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/xpb_accum_csa_3to2.sv
// One row of 3:2 carry-save compressors: bitwise sum plus majority carry
// shifted up one position, truncated to W bits.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/xpb_accum.sv
// Accumulates NUM_TERMS xpb terms onto base_in in carry-save form, then resolves
// the redundant sum SEG bits per cycle. Optional abort input: XPB_ACCUM_ABORT_EN.
module xpb_accum
    import xpb_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
`ifdef XPB_ACCUM_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] base_in,
    input  logic             xpb_valid,
    input  logic [WIDTH-1:0] xpb_data,
    output logic             xpb_ready,
    output logic             res_valid,
    output logic [RW-1:0]    res_data,
    input  logic             res_ready,
    output logic             busy
);

    localparam int BASE_W = $clog2(NSEG * SEG);

    state_t               state_q;
    logic [RW-1:0]        sum_q;
    logic [RW-1:0]        carry_q;
    logic [RW-1:0]        res_q;
    logic [COUNT_W-1:0]   count_q;
    logic [SEG_IDX_W-1:0] seg_idx_q;
    logic                 cin_q;

    logic [RW-1:0]        csa_sum;
    logic [RW-1:0]        csa_carry;
    logic                 abort_hit;

    logic [BASE_W-1:0]    seg_base;
    logic [SEG-1:0]       sum_seg;
    logic [SEG-1:0]       carry_seg;
    logic [SEG:0]         seg_add;
    logic [RW-1:0]        seg_mask;
    logic [RW-1:0]        res_next;

`ifdef XPB_ACCUM_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    csa_3to2 #(.W(RW)) u_csa (
        .a     (sum_q),
        .b     (carry_q),
        .c     ({{GUARD{1'b0}}, xpb_data}),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Segment select by shift/mask so the short top segment needs no padding;
    // bits past RW fall off, which is exactly the mod 2^RW discard.
    assign seg_base  = BASE_W'(seg_idx_q) * BASE_W'(SEG);
    assign sum_seg   = SEG'(sum_q >> seg_base);
    assign carry_seg = SEG'(carry_q >> seg_base);
    assign seg_add   = {1'b0, sum_seg} + {1'b0, carry_seg} + {{SEG{1'b0}}, cin_q};
    assign seg_mask  = {{(RW-SEG){1'b0}}, {SEG{1'b1}}} << seg_base;
    assign res_next  = (res_q & ~seg_mask)
                     | (({{(RW-SEG){1'b0}}, seg_add[SEG-1:0]} << seg_base) & seg_mask);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            carry_q   <= '0;
            res_q     <= '0;
            count_q   <= '0;
            seg_idx_q <= '0;
            cin_q     <= 1'b0;
        end else if (abort_hit) begin
            state_q   <= IDLE;
            count_q   <= '0;
            seg_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_q   <= {{GUARD{1'b0}}, base_in};
                        carry_q <= '0;
                        count_q <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xpb_valid) begin
                        sum_q   <= csa_sum;
                        carry_q <= csa_carry;
                        count_q <= count_q + COUNT_W'(1);
                        if (count_q == COUNT_W'(NUM_TERMS - 1)) begin
                            seg_idx_q <= '0;
                            cin_q     <= 1'b0;
                            state_q   <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    res_q <= res_next;
                    cin_q <= seg_add[SEG];
                    if (seg_idx_q == SEG_IDX_W'(NSEG - 1)) begin
                        seg_idx_q <= '0;
                        state_q   <= OUT;
                    end else begin
                        seg_idx_q <= seg_idx_q + SEG_IDX_W'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign xpb_ready = (state_q == ACCUM);
    assign res_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_q;

endmodule
